// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared synchronous data RAM: one RAM access at a time.
// Define DM_ARB_CPU_PRIO_EN for fixed priority to master 0; default is round-robin.
module dm_bus_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Reads always pass through WAIT for RD_LAT cycles so the RAM data lands in
    // rdata_q on the edge leaving cycle ISSUE+RD_LAT.
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          win;

    always_comb begin
        win = 1'b0;
`ifdef DM_ARB_CPU_PRIO_EN
        win = !m0_req;
`else
        if (m0_req && m1_req) begin
            win = !last_grant_q;
        end else begin
            win = m1_req;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = S_ISSUE;
                    gnt_d        = win;
                    last_grant_d = win;
                    we_d         = win ? m1_we    : m0_we;
                    addr_d       = win ? m1_addr  : m0_addr;
                    wdata_d      = win ? m1_wdata : m0_wdata;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = ram_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // All outputs decode from registered state, so reset forces them low at once.
    assign ram_en    = (state_q == S_ISSUE);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_ack    = (state_q == S_RESP) && !gnt_q;
    assign m1_ack    = (state_q == S_RESP) && gnt_q;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Scoreboard bench for dm_bus_arbiter: RD_LAT=1 instance for most traffic, RD_LAT=3 instance for latency.
`timescale 1ns/1ps
module tb_dm_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata, a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic        a_ram_en, a_ram_we, a_busy;
    logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

    logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_ram_en, b_ram_we, b_busy;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    dm_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    dm_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // RAM model A: 1-cycle read data, present only in the cycle it is valid.
    logic [31:0] mem_a [0:63];
    logic [31:0] a_pipe;
    always @(posedge clk) begin
        if (!rst) begin
            mem_a[4]  <= 32'hDEADBEEF;
            mem_a[12] <= 32'hA5A55A5A;
        end else if (a_ram_en && a_ram_we) begin
            mem_a[a_ram_addr[7:2]] <= a_ram_wdata;
        end
        a_pipe <= (a_ram_en && !a_ram_we) ? mem_a[a_ram_addr[7:2]] : 32'h0;
    end
    assign a_ram_rdata = a_pipe;

    // RAM model B: 3-cycle read latency, constant read pattern.
    logic [31:0] b_p0, b_p1, b_p2;
    always @(posedge clk) begin
        b_p0 <= (b_ram_en && !b_ram_we) ? 32'h0BADF00D : 32'h0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_ram_rdata = b_p2;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   a_ram_en_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic id, input logic [31:0] rd);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        if (a_ram_en) a_ram_en_cnt++;
        if (a_m0_ack || a_m1_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: actual m0_ack=%0b m1_ack=%0b required none",
                         a_m0_ack, a_m1_ack);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_onehot", 32'(a_m0_ack && a_m1_ack), 32'd0);
                chk("ack_master", 32'(a_m1_ack), 32'(mon_e.id));
                chk("ack_rdata", mon_e.id ? a_m1_rdata : a_m0_rdata, mon_e.rdata);
            end
        end
    end

    task automatic set_req(input logic id, input logic v);
        if (id) a_m1_req = v;
        else    a_m0_req = v;
    endtask

    task automatic txn(input logic id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_lat);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        sb_push(id, exp_rd);
        if (id) begin a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wdata; end
        else    begin a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wdata; end
        set_req(id, 1'b1);
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("ram_en_c1", 32'(a_ram_en), 32'd1);
                chk("ram_we_c1", 32'(a_ram_we), 32'(we));
                chk("ram_addr_c1", a_ram_addr, addr);
                if (we) chk("ram_wdata_c1", a_ram_wdata, wdata);
            end
            if (id ? a_m1_ack : a_m0_ack) begin
                seen = 1'b1;
                chk("ack_cycle", 32'(cyc), 32'(exp_lat));
                set_req(id, 1'b0);
            end
        end
        if (!seen) begin
            chk("txn_timeout", 32'd0, 32'd1);
            set_req(id, 1'b0);
        end
    endtask

    int acks;
    int m1_acks;
    int en_base;

    initial begin
        rst = 1'b0;
        a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset asserted while the read sits in WAIT
        @(posedge clk); #1;
        a_m0_we = 0; a_m0_addr = 32'h10; a_m0_req = 1;
        @(posedge clk); @(posedge clk); #1;
        chk("busy_in_wait", 32'(a_busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ram_en", 32'(a_ram_en), 32'd0);
        chk("rst_ram_we", 32'(a_ram_we), 32'd0);
        chk("rst_ram_addr", a_ram_addr, 32'd0);
        chk("rst_acks", 32'({a_m0_ack, a_m1_ack}), 32'd0);
        chk("rst_rdata", a_m0_rdata, 32'd0);
        a_m0_req = 0;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({a_ram_en, a_busy}), 32'd0);
        end

        // m0 read, m1 write
        txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        txn(1'b1, 1'b1, 32'h20, 32'h1234, 32'hDEADBEEF, 2);

        // Both masters held for four grants
        @(posedge clk); #1;
`ifdef DM_ARB_CPU_PRIO_EN
        for (int i = 0; i < 4; i++) sb_push(1'b0, 32'hDEADBEEF);
`else
        sb_push(1'b0, 32'hDEADBEEF); sb_push(1'b1, 32'h1234);
        sb_push(1'b0, 32'hDEADBEEF); sb_push(1'b1, 32'h1234);
`endif
        a_m0_we = 0; a_m0_addr = 32'h10; a_m1_we = 0; a_m1_addr = 32'h20;
        a_m0_req = 1; a_m1_req = 1;
        acks = 0;
        for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
            @(negedge clk);
            if (a_m0_ack || a_m1_ack) acks++;
            if (acks == 4) begin a_m0_req = 0; a_m1_req = 0; end
        end
        a_m0_req = 0; a_m1_req = 0;
        chk("rr_ack_count", 32'(acks), 32'd4);

        // m1 read whose req drops during WAIT
        @(posedge clk); #1;
        en_base = a_ram_en_cnt;
        sb_push(1'b1, 32'hA5A55A5A);
        a_m1_we = 0; a_m1_addr = 32'h30; a_m1_req = 1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        a_m1_req = 0;
        m1_acks = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (a_m1_ack) m1_acks++;
        end
        chk("drop_ack_count", 32'(m1_acks), 32'd1);
        chk("drop_ram_en_count", 32'(a_ram_en_cnt - en_base), 32'd1);

        // Write leaves rdata untouched; read back new word
        txn(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 32'hA5A55A5A, 2);
        txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 3);

        // RD_LAT=3 instance: ram_en cycle 1, ack cycle 5, busy cycles 1..5
        @(posedge clk); #1;
        b_m0_we = 0; b_m0_addr = 32'h80; b_m0_req = 1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            chk("lat3_busy", 32'(b_busy), 32'(cyc >= 1 && cyc <= 5));
            chk("lat3_ram_en", 32'(b_ram_en), 32'(cyc == 1));
            chk("lat3_m0_ack", 32'(b_m0_ack), 32'(cyc == 5));
            chk("lat3_m1_ack", 32'(b_m1_ack), 32'd0);
            if (cyc == 5) chk("lat3_rdata", b_m0_rdata, 32'h0BADF00D);
            if (b_m0_ack) b_m0_req = 0;
        end
        b_m0_req = 0;

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
